// File: rtl/id_ex_hazard_if.sv
// ID/EX bus: ID-stage operands/control in, EX-stage copies and hazard stalls out.
// master = pipeline/ID side, slave = id_ex_hazard_reg.
interface id_ex_hazard_if #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 4
);
  localparam int unsigned CTRL_W = 6 + ALU_OP_W;

  logic                  hold_i;
  logic                  flush_i;
  logic                  id_valid_i;
  logic [XLEN-1:0]       id_pc_i;
  logic [REG_ADDR_W-1:0] id_rs1_addr_i;
  logic [REG_ADDR_W-1:0] id_rs2_addr_i;
  logic                  id_uses_rs1_i;
  logic                  id_uses_rs2_i;
  logic [REG_ADDR_W-1:0] id_rd_addr_i;
  logic [XLEN-1:0]       id_rs1_data_i;
  logic [XLEN-1:0]       id_rs2_data_i;
  logic [XLEN-1:0]       id_imm_i;
  logic [CTRL_W-1:0]     id_ctrl_i;
  logic                  id_alusrc_i;

  logic                  ex_valid_o;
  logic [XLEN-1:0]       ex_pc_o;
  logic [REG_ADDR_W-1:0] ex_rs1_addr_o;
  logic [REG_ADDR_W-1:0] ex_rs2_addr_o;
  logic [REG_ADDR_W-1:0] ex_rd_addr_o;
  logic [XLEN-1:0]       ex_rs1_data_o;
  logic [XLEN-1:0]       ex_rs2_data_o;
  logic [XLEN-1:0]       ex_imm_o;
  logic [CTRL_W-1:0]     ex_ctrl_o;
  logic                  ex_alusrc_o;
  logic                  stall_o;
  logic                  load_use_o;

  modport master (
    output hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
           id_uses_rs1_i, id_uses_rs2_i, id_rd_addr_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_ctrl_i, id_alusrc_i,
    input  ex_valid_o, ex_pc_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_ctrl_o, ex_alusrc_o,
           stall_o, load_use_o
  );

  modport slave (
    input  hold_i, flush_i, id_valid_i, id_pc_i, id_rs1_addr_i, id_rs2_addr_i,
           id_uses_rs1_i, id_uses_rs2_i, id_rd_addr_i, id_rs1_data_i, id_rs2_data_i,
           id_imm_i, id_ctrl_i, id_alusrc_i,
    output ex_valid_o, ex_pc_o, ex_rs1_addr_o, ex_rs2_addr_o, ex_rd_addr_o,
           ex_rs1_data_o, ex_rs2_data_o, ex_imm_o, ex_ctrl_o, ex_alusrc_o,
           stall_o, load_use_o
  );
endinterface

// File: rtl/id_ex_hazard_reg.sv
// ID/EX pipeline register with load-use bubble insertion and hold/flush handling.
// Optional load-use bubble counter (lu_bubble_cnt_o) when ID_EX_PERF_CNT_EN is defined.
module id_ex_hazard_reg #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned REG_ADDR_W = 5,
  parameter int unsigned ALU_OP_W   = 4
) (
  input  logic          clk,
  input  logic          rst_n,
  id_ex_hazard_if.slave bus
`ifdef ID_EX_PERF_CNT_EN
  ,
  output logic [31:0]   lu_bubble_cnt_o
`endif
);
  localparam int unsigned CTRL_W       = 6 + ALU_OP_W;
  localparam int unsigned REGWRITE_BIT = ALU_OP_W + 5;
  localparam int unsigned MEMREAD_BIT  = ALU_OP_W + 4;
  // RegWrite, MemRead, MemWrite, Branch, Jump; MemtoReg and alu_op are selects, not enables
  localparam logic [CTRL_W-1:0] EN_MASK = CTRL_W'(6'b111011) << ALU_OP_W;

  logic                  valid_q,    valid_d;
  logic [XLEN-1:0]       pc_q,       pc_d;
  logic [REG_ADDR_W-1:0] rs1_q,      rs1_d;
  logic [REG_ADDR_W-1:0] rs2_q,      rs2_d;
  logic [REG_ADDR_W-1:0] rd_q,       rd_d;
  logic [XLEN-1:0]       d1_q,       d1_d;
  logic [XLEN-1:0]       d2_q,       d2_d;
  logic [XLEN-1:0]       imm_q,      imm_d;
  logic [CTRL_W-1:0]     ctrl_q,     ctrl_d;
  logic                  alusrc_q,   alusrc_d;
  logic                  flush_pend_q, flush_pend_d;

  logic lu;
  logic flush_eff;
  logic stall_c;
  logic load_use_c;

  // Load-use hazard: ID reads the destination of a real load sitting in EX
  always_comb begin
    lu = 1'b0;
    if (valid_q && ctrl_q[MEMREAD_BIT] && ctrl_q[REGWRITE_BIT] &&
        (rd_q != '0) && bus.id_valid_i) begin
      lu = (bus.id_uses_rs1_i && (bus.id_rs1_addr_i == rd_q)) ||
           (bus.id_uses_rs2_i && (bus.id_rs2_addr_i == rd_q));
    end
    flush_eff  = bus.flush_i | flush_pend_q;
    stall_c    = rst_n & (bus.hold_i | (lu & ~flush_eff));
    load_use_c = rst_n & ~bus.hold_i & lu & ~flush_eff;
  end

  // Next EX contents: hold > flush bubble > load-use bubble > load
  always_comb begin
    valid_d      = valid_q;
    pc_d         = pc_q;
    rs1_d        = rs1_q;
    rs2_d        = rs2_q;
    rd_d         = rd_q;
    d1_d         = d1_q;
    d2_d         = d2_q;
    imm_d        = imm_q;
    ctrl_d       = ctrl_q;
    alusrc_d     = alusrc_q;
    flush_pend_d = flush_pend_q;

    if (bus.hold_i) begin
      if (bus.flush_i) flush_pend_d = 1'b1;
    end else if (flush_eff || lu) begin
      // Zeroed addresses keep forwarding from matching the bubble
      valid_d      = 1'b0;
      rs1_d        = '0;
      rs2_d        = '0;
      rd_d         = '0;
      ctrl_d       = ctrl_q & ~EN_MASK;
      flush_pend_d = 1'b0;
    end else begin
      valid_d  = bus.id_valid_i;
      pc_d     = bus.id_pc_i;
      rs1_d    = bus.id_rs1_addr_i;
      rs2_d    = bus.id_rs2_addr_i;
      rd_d     = bus.id_rd_addr_i;
      d1_d     = bus.id_rs1_data_i;
      d2_d     = bus.id_rs2_data_i;
      imm_d    = bus.id_imm_i;
      ctrl_d   = bus.id_valid_i ? bus.id_ctrl_i : (bus.id_ctrl_i & ~EN_MASK);
      alusrc_d = bus.id_alusrc_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q      <= 1'b0;
      pc_q         <= '0;
      rs1_q        <= '0;
      rs2_q        <= '0;
      rd_q         <= '0;
      d1_q         <= '0;
      d2_q         <= '0;
      imm_q        <= '0;
      ctrl_q       <= '0;
      alusrc_q     <= 1'b0;
      flush_pend_q <= 1'b0;
    end else begin
      valid_q      <= valid_d;
      pc_q         <= pc_d;
      rs1_q        <= rs1_d;
      rs2_q        <= rs2_d;
      rd_q         <= rd_d;
      d1_q         <= d1_d;
      d2_q         <= d2_d;
      imm_q        <= imm_d;
      ctrl_q       <= ctrl_d;
      alusrc_q     <= alusrc_d;
      flush_pend_q <= flush_pend_d;
    end
  end

`ifdef ID_EX_PERF_CNT_EN
  logic [31:0] lu_cnt_q;

  // Wraps naturally; load_use_c is already low while held
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)          lu_cnt_q <= '0;
    else if (load_use_c) lu_cnt_q <= lu_cnt_q + 32'd1;
  end

  assign lu_bubble_cnt_o = lu_cnt_q;
`endif

  assign bus.ex_valid_o    = valid_q;
  assign bus.ex_pc_o       = pc_q;
  assign bus.ex_rs1_addr_o = rs1_q;
  assign bus.ex_rs2_addr_o = rs2_q;
  assign bus.ex_rd_addr_o  = rd_q;
  assign bus.ex_rs1_data_o = d1_q;
  assign bus.ex_rs2_data_o = d2_q;
  assign bus.ex_imm_o      = imm_q;
  assign bus.ex_ctrl_o     = ctrl_q;
  assign bus.ex_alusrc_o   = alusrc_q;
  assign bus.stall_o       = stall_c;
  assign bus.load_use_o    = load_use_c;
endmodule
